clock_div_prog: RTL and testbench
=================================

// Module: clock_div_prog
// PURPOSE
//  Parametrised runtime-programmable clock divider and tick generator for the TM1638 driver path.
//  Produces a divided clock-enable-style square wave (clko), a one-cycle period tick and, optionally,
//  edge-anticipation strobes for bit-banged serial timing. Divisor can be changed on the fly;
//  the change takes effect only at a period boundary, so clko never glitches.
// PARAMETERS
//  CNT_W        27   width of counter and divisor (max divisor 2**CNT_W-1)
//  DIV_DEFAULT  64   divisor loaded at reset (64 => clko = clki/64, low 32 / high 32)
// PORTS
//  clki      in   1      system clock, all logic on posedge
//  rst_n     in   1      asynchronous active-low reset
//  en        in   1      count enable; 0 freezes counter and clko
//  div_val   in   CNT_W  requested divisor N
//  div_load  in   1      1-cycle strobe: capture div_val as pending divisor
//  div_ack   out  1      1-cycle pulse: pending divisor has been applied
//  clko      out  1      divided clock, registered
//  tick      out  1      high for the single cycle where cnt==N-1 and en==1
//  cnt       out  CNT_W  current phase counter, 0..N-1
//  rise_stb  out  1      pre-rise strobe (see CONFIGURATION)
//  fall_stb  out  1      pre-fall strobe (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): cnt=0, clko=0, div_ack=0, pend=0, div_reg=clamp(DIV_DEFAULT).
//  - Effective divisor N=div_reg; any value <2 is clamped to 2 (at capture and for DIV_DEFAULT).
//  - en=1 each edge: cnt <= (cnt==N-1) ? 0 : cnt+1. clko <= (cnt_next >= N/2), N/2 = floor.
//    => clko low for floor(N/2) cycles, high for ceil(N/2); odd N gives the extra cycle high.
//  - en=0: cnt, clko hold; tick=0; strobes=0.
//  - tick = en & (cnt==N-1), decoded from registers; exactly one pulse per N enabled cycles.
//  - Divisor update, two states: IDLE (pend=0), PEND (pend=1, pend_val holds value).
//    IDLE --div_load--> PEND: pend_val <= clamp(div_val).
//    PEND, div_load again: pend_val overwritten, stay PEND (one ack total).
//    PEND, en=1 and cnt==N-1 (wrap edge): div_reg<=pend_val, cnt<=0, clko<=0, pend<=0,
//      div_ack<=1 for the next cycle -> IDLE.
//    PEND, en=0: applied on the next edge regardless of cnt; cnt<=0, clko<=0, ack as above.
//    div_load on the same edge as a wrap: value goes to pend_val, NOT applied at this wrap;
//      applied at the following wrap.
//  - div_ack registered, high exactly 1 cycle, otherwise 0.
//  - Reset mid-operation: all state cleared immediately; pending value discarded, no ack.
//  - Counter arithmetic in CNT_W bits; cnt never exceeds N-1, no overflow path.
// CONFIGURATION
//  - Macro CLOCK_DIV_EDGE_STB_EN defined:
//    rise_stb = en & (cnt==N/2-1)  (cycle before clko rises)
//    fall_stb = en & (cnt==N-1)    (cycle before clko falls; equals tick)
//  - Not defined: rise_stb and fall_stb tied to constant 0; decode logic absent.
// TESTING
//  1. Reset, en=1, defaults -> clko low 32 / high 32 cycles, tick once per 64 at cnt==63, div_ack=0.
//  2. div_load with div_val=5 mid-period -> old period completes; then clko low 2 / high 3,
//     tick every 5; div_ack one pulse on cycle after the wrap.
//  3. div_val=0 and 1 loaded -> clamped to N=2: clko toggles every cycle, tick every 2 cycles.
//  4. en=0 at cnt==10 for 7 cycles -> cnt stays 10, clko holds, tick=0; en=1 resumes at cnt=11.
//  5. div_load(7) then div_load(9) before wrap, also div_load on a wrap edge ->
//     only 9 applied, single div_ack; value loaded on the wrap applied one period later.
//  6. rst_n low at cnt==40 with pending divisor -> cnt=0, clko=0 immediately; N=64, no ack.
//     With CLOCK_DIV_EDGE_STB_EN, N=64: rise_stb at cnt==31, fall_stb at cnt==63;
//     without it both stay 0.

Source files
------------

// File: rtl/clock_div_prog_if.sv
// Control/status bundle for clock_div_prog: enable, divisor update handshake,
// divided clock, period tick, phase counter and edge-anticipation strobes.
interface clock_div_prog_if #(
  parameter int CNT_W = 27
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             clko;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             rise_stb;
  logic             fall_stb;

  modport master (
    output en, div_val, div_load,
    input  div_ack, clko, tick, cnt, rise_stb, fall_stb
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ack, clko, tick, cnt, rise_stb, fall_stb
  );
endinterface

// File: rtl/clock_div_prog.sv
// Runtime-programmable clock divider / tick generator; divisor changes land only on a
// period boundary. Define CLOCK_DIV_EDGE_STB_EN to enable pre-rise/pre-fall strobes.
module clock_div_prog #(
  parameter int CNT_W       = 27,
  parameter int DIV_DEFAULT = 64
) (
  input logic             clki,
  input logic             rst_n,
  clock_div_prog_if.slave bus
);

  typedef enum logic {UPD_IDLE, UPD_PEND} upd_state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST = (DIV_DEFAULT < 2) ? TWO : CNT_W'(DIV_DEFAULT);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  upd_state_t       upd_state;
  logic [CNT_W-1:0] pend_val;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt_q;
  logic             clko_q;
  logic             ack_q;
  logic             last;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    last    = (cnt_q == div_reg - ONE);
    cnt_inc = last ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      upd_state <= UPD_IDLE;
      pend_val  <= '0;
      div_reg   <= DIV_RST;
      cnt_q     <= '0;
      clko_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (bus.en) begin
        cnt_q  <= cnt_inc;
        clko_q <= (cnt_inc >= (div_reg >> 1));
      end
      // A fresh load always wins: it refreshes pend_val and defers the switch to a later boundary.
      if (bus.div_load) begin
        pend_val  <= clamp_div(bus.div_val);
        upd_state <= UPD_PEND;
      end else if (upd_state == UPD_PEND && (!bus.en || last)) begin
        div_reg   <= pend_val;
        cnt_q     <= '0;
        clko_q    <= 1'b0;
        ack_q     <= 1'b1;
        upd_state <= UPD_IDLE;
      end
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.clko    = clko_q;
  assign bus.div_ack = ack_q;
  assign bus.tick    = bus.en & last;

`ifdef CLOCK_DIV_EDGE_STB_EN
  assign bus.rise_stb = bus.en & (cnt_q == (div_reg >> 1) - ONE);
  assign bus.fall_stb = bus.en & last;
`else
  assign bus.rise_stb = 1'b0;
  assign bus.fall_stb = 1'b0;
`endif

endmodule

// File: tb/tb_clock_div_prog.sv
// Directed bench for clock_div_prog: defaults, divisor updates, clamping, enable freeze,
// load coalescing and reset while a divisor is pending.
module tb_clock_div_prog;
  localparam int CNT_W = 27;

  logic clki;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   n;        // expected effective divisor
  int   ph;       // expected phase
  logic ack_exp;  // expected div_ack at the next run() sample

  clock_div_prog_if #(.CNT_W(CNT_W)) bus ();

  clock_div_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(64)) dut (
    .clki  (clki),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Check n enabled cycles against the expected phase, advancing one clock each.
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk("cnt", 32'(bus.cnt), 32'(ph));
      chk("clko", 32'(bus.clko), 32'(ph >= n / 2));
      chk("tick", 32'(bus.tick), 32'(ph == n - 1));
      chk("div_ack", 32'(bus.div_ack), 32'(ack_exp));
`ifdef CLOCK_DIV_EDGE_STB_EN
      chk("rise_stb", 32'(bus.rise_stb), 32'(ph == n / 2 - 1));
      chk("fall_stb", 32'(bus.fall_stb), 32'(ph == n - 1));
`else
      chk("rise_stb", 32'(bus.rise_stb), 32'd0);
      chk("fall_stb", 32'(bus.fall_stb), 32'd0);
`endif
      ack_exp = 1'b0;
      @(negedge clki);
      ph = (ph == n - 1) ? 0 : ph + 1;
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    ack_exp  = 1'b0;
    rst_n    = 1'b0;
    bus.en       = 1'b0;
    bus.div_val  = '0;
    bus.div_load = 1'b0;

    // Async reset state before any clock edge
    #2;
    chk("rst_cnt", 32'(bus.cnt), 32'd0);
    chk("rst_clko", 32'(bus.clko), 32'd0);
    chk("rst_ack", 32'(bus.div_ack), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    @(negedge clki);
    @(negedge clki);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    n  = 64;
    ph = 0;

    // 1: defaults, N=64
    run(140);                       // ph = 12

    // 2: load 5 mid-period, old period completes first
    bus.div_val = 27'd5; bus.div_load = 1'b1;
    run(1);
    bus.div_load = 1'b0;
    run(51);                        // through the wrap at ph 63
    n = 5; ack_exp = 1'b1;
    run(12);                        // ph = 2

    // 3: clamp 0 and 1 to N=2
    bus.div_val = 27'd0; bus.div_load = 1'b1;
    run(1);
    bus.div_load = 1'b0;
    run(2);
    n = 2; ack_exp = 1'b1;
    run(6);                         // ph = 0
    bus.div_val = 27'd1; bus.div_load = 1'b1;
    run(1);
    bus.div_load = 1'b0;
    run(1);
    ack_exp = 1'b1;
    run(4);                         // ph = 0

    // 4: N=20, freeze at cnt 10 for 7 cycles
    bus.div_val = 27'd20; bus.div_load = 1'b1;
    run(1);
    bus.div_load = 1'b0;
    run(1);
    n = 20; ack_exp = 1'b1;
    run(10);                        // ph = 10
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("hold_cnt", 32'(bus.cnt), 32'd10);
      chk("hold_clko", 32'(bus.clko), 32'd1);
      chk("hold_tick", 32'(bus.tick), 32'd0);
      chk("hold_rise", 32'(bus.rise_stb), 32'd0);
      chk("hold_fall", 32'(bus.fall_stb), 32'd0);
      @(negedge clki);
    end
    bus.en = 1'b1;
    chk("resume_cnt0", 32'(bus.cnt), 32'd10);
    @(negedge clki);
    chk("resume_cnt1", 32'(bus.cnt), 32'd11);
    ph = 11;
    run(9);                         // ph = 0

    // 5: 7 then 9 before the wrap -> only 9, one ack
    bus.div_val = 27'd7; bus.div_load = 1'b1;
    run(1);
    bus.div_val = 27'd9;
    run(1);
    bus.div_load = 1'b0;
    run(18);                        // includes wrap at ph 19
    n = 9; ack_exp = 1'b1;
    run(8);                         // ph = 8 (wrap edge next)
    bus.div_val = 27'd6; bus.div_load = 1'b1;
    run(1);                         // load on the wrap: not applied here
    bus.div_load = 1'b0;
    run(9);
    n = 6; ack_exp = 1'b1;
    run(8);                         // ph = 2

    // 6: back to 64, reset at cnt 40 with a divisor pending
    bus.div_val = 27'd64; bus.div_load = 1'b1;
    run(1);
    bus.div_load = 1'b0;
    run(3);
    n = 64; ack_exp = 1'b1;
    run(39);                        // ph = 39
    bus.div_val = 27'd7; bus.div_load = 1'b1;
    run(1);                         // ph = 40, 7 pending
    bus.div_load = 1'b0;
    chk("pre_rst_cnt", 32'(bus.cnt), 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(bus.cnt), 32'd0);
    chk("mid_rst_clko", 32'(bus.clko), 32'd0);
    chk("mid_rst_ack", 32'(bus.div_ack), 32'd0);
    @(negedge clki);
    rst_n = 1'b1;
    ph = 0;
    ack_exp = 1'b0;
    run(70);                        // N=64 kept, no ack at the wrap

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
